// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter with a starvation guard. It shares one single-port memory between
// instruction fetch and data access, and it issues one registered transaction at a time.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] LimitCnt = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BeW-1:0]    mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fetch_forced;

  // A waiting fetch takes the memory once data has won STARVE_LIMIT contested rounds.
  assign fetch_forced = if_req && (starve_q == LimitCnt);

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_req && !fetch_forced) begin
          state_d     = StGntD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_req && (starve_q != LimitCnt)) begin
            starve_d = starve_q + CntW'(1);
          end
        end else if (if_req) begin
          state_d     = StGntI;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      StGntI: begin
        if (mem_ready) begin
          if_ack    = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StGntD: begin
        if (mem_ready) begin
          d_ack     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0050_0093;
  logic        mem_ready = 1'b1;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction record plus the count of data wins over a waiting fetch.
  logic        m_busy = 1'b0;
  logic        m_fetch = 1'b0;
  int          m_wins = 0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 1'b0; m_fetch = 1'b0; m_wins = 0;
      m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    end else if (m_busy) begin
      if (mem_ready) m_busy = 1'b0;
    end else if (if_req && (!d_req || m_wins >= SL)) begin
      m_busy = 1'b1; m_fetch = 1'b1; m_wins = 0;
      m_we = 1'b0; m_be = 4'hF; m_addr = if_addr; m_wdata = '0;
    end else if (d_req) begin
      m_busy = 1'b1; m_fetch = 1'b0;
      if (if_req) m_wins = (m_wins + 1 > SL) ? SL : m_wins + 1;
      m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
    end
  end

  function automatic logic model_if_ack();
    return m_busy && m_fetch && mem_ready;
  endfunction

  function automatic logic model_d_ack();
    return m_busy && !m_fetch && mem_ready;
  endfunction

  initial forever begin
    @(negedge clk);
    check("m_mem_req", 64'(mem_req), 64'(m_busy));
    check("m_mem_we", 64'(mem_we), 64'(m_we));
    check("m_mem_be", 64'(mem_be), 64'(m_be));
    check("m_mem_addr", 64'(mem_addr), 64'(m_addr));
    check("m_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check("m_if_ack", 64'(if_ack), 64'(model_if_ack()));
    check("m_d_ack", 64'(d_ack), 64'(model_d_ack()));
    check("m_stall_if", 64'(stall_if), 64'(if_req && !model_if_ack()));
    check("m_stall_mem", 64'(stall_mem), 64'(d_req && !model_d_ack()));
    if (model_if_ack()) check("m_if_rdata", 64'(if_rdata), 64'(mem_rdata));
    if (model_d_ack() && !m_we) check("m_d_rdata", 64'(d_rdata), 64'(mem_rdata));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic ifa = 1'b0;
  logic da = 1'b0;

  initial begin
    // Reset values
    #2;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_if_ack", 64'(if_ack), 64'd0);
    check("rst_d_ack", 64'(d_ack), 64'd0);
    step(); reset = 1'b1;
    step();

    // Single fetch
    step(); if_req = 1'b1; if_addr = 32'h100; #3;
    check("sf_stall_c0", 64'(stall_if), 64'd1);
    check("sf_mem_req_c0", 64'(mem_req), 64'd0);
    step(); #3;
    check("sf_mem_req_c1", 64'(mem_req), 64'd1);
    check("sf_mem_addr_c1", 64'(mem_addr), 64'h100);
    check("sf_mem_we_c1", 64'(mem_we), 64'd0);
    check("sf_if_ack_c1", 64'(if_ack), 64'd1);
    check("sf_if_rdata_c1", 64'(if_rdata), 64'h0050_0093);
    check("sf_stall_c1", 64'(stall_if), 64'd0);
    step(); if_req = 1'b0;

    // Contention
    step(); if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h2000; d_be = 4'hF;
    step(); #3;
    check("ct_d_ack_c1", 64'(d_ack), 64'd1);
    check("ct_if_ack_c1", 64'(if_ack), 64'd0);
    check("ct_addr_c1", 64'(mem_addr), 64'h2000);
    step(); d_req = 1'b0; #3;
    check("ct_mem_req_c2", 64'(mem_req), 64'd0);
    step(); #3;
    check("ct_if_ack_c3", 64'(if_ack), 64'd1);
    check("ct_addr_c3", 64'(mem_addr), 64'h104);
    step(); if_req = 1'b0;

    // Starvation: data acks at 1,3,5,7, fetch at 9, queued load at 11
    step(); if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h4000;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 2 || c == 4 || c == 6 || c == 8) d_addr = d_addr + 32'd4;
      if (c == 10) if_req = 1'b0;
      #3;
      check($sformatf("sv_d_ack_c%0d", c), 64'(d_ack),
            64'(c == 1 || c == 3 || c == 5 || c == 7 || c == 11));
      check($sformatf("sv_if_ack_c%0d", c), 64'(if_ack), 64'(c == 9));
      if (c == 9) begin
        check("sv_mem_req_c9", 64'(mem_req), 64'd1);
        check("sv_addr_c9", 64'(mem_addr), 64'h200);
      end
    end
    step(); d_req = 1'b0;

    // Store with three wait states
    step(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h3000;
    d_wdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step(); mem_ready = (c == 4); #3;
      check($sformatf("ws_mem_req_c%0d", c), 64'(mem_req), 64'd1);
      check($sformatf("ws_mem_we_c%0d", c), 64'(mem_we), 64'd1);
      check($sformatf("ws_mem_be_c%0d", c), 64'(mem_be), 64'h3);
      check($sformatf("ws_mem_addr_c%0d", c), 64'(mem_addr), 64'h3000);
      check($sformatf("ws_mem_wdata_c%0d", c), 64'(mem_wdata), 64'hDEAD_BEEF);
      check($sformatf("ws_d_ack_c%0d", c), 64'(d_ack), 64'(c == 4));
      check($sformatf("ws_stall_c%0d", c), 64'(stall_mem), 64'(c != 4));
    end
    step(); d_req = 1'b0; d_we = 1'b0;

    // Reset during an in-flight load
    step(); d_req = 1'b1; d_addr = 32'h5000; mem_ready = 1'b0;
    step(); #1;
    check("rm_mem_req_pre", 64'(mem_req), 64'd1);
    reset = 1'b0; #1;
    check("rm_mem_req_rst", 64'(mem_req), 64'd0);
    mem_ready = 1'b1; #1;
    check("rm_d_ack_rst", 64'(d_ack), 64'd0);
    step(); d_req = 1'b0; #1; reset = 1'b1;
    step(); if_req = 1'b1; if_addr = 32'h600; #3;
    check("rm_if_ack_c0", 64'(if_ack), 64'd0);
    step(); #3;
    check("rm_mem_req_c1", 64'(mem_req), 64'd1);
    check("rm_if_ack_c1", 64'(if_ack), 64'd1);
    check("rm_addr_c1", 64'(mem_addr), 64'h600);
    step(); if_req = 1'b0;

    // Random traffic; requesters honour the hold-until-ack protocol using the model's acks
    ifa = 1'b0; da = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (ifa || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if (if_req) if_addr = $urandom;
      end
      if (da || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        if (d_req) begin
          d_we = 1'($urandom);
          d_be = 4'($urandom);
          d_addr = $urandom;
          d_wdata = $urandom;
        end
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      #1;
      ifa = model_if_ack();
      da = model_d_ack();
    end
    step(); if_req = 1'b0; d_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
